// File: rtl/seq_priority_encoder.sv
// Sequential 8:3 encoder: accepts a multi-hot word and emits the index of each
// set bit, lowest first, one beat per accepted transfer.
module seq_priority_encoder #(
    parameter int W     = 8,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_word,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic             zero_flag,
    output logic             busy
);

    typedef enum logic {IDLE, EMIT} state_t;

    state_t           state, state_n;
    logic [W-1:0]     pending, pending_n, rem;
    logic             in_ready_n, out_valid_n, out_last_n, zero_flag_n, busy_n;
    logic [IDX_W-1:0] out_idx_n;

    function automatic logic [IDX_W-1:0] lsb_idx(input logic [W-1:0] v);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = W - 1; i >= 0; i--)
            if (v[i]) r = IDX_W'(i);
        return r;
    endfunction

    function automatic logic single_bit(input logic [W-1:0] v);
        return (v != '0) && ((v & (v - W'(1))) == '0);
    endfunction

    // Clearing the lowest set bit is exactly the bit currently on out_idx.
    assign rem = pending & (pending - W'(1));

    always_comb begin
        state_n     = state;
        pending_n   = pending;
        in_ready_n  = in_ready;
        out_valid_n = out_valid;
        out_idx_n   = out_idx;
        out_last_n  = out_last;
        zero_flag_n = 1'b0;
        busy_n      = busy;
        case (state)
            IDLE: begin
                in_ready_n = 1'b1;
                if (in_valid && in_ready) begin
                    if (in_word != '0) begin
                        state_n     = EMIT;
                        pending_n   = in_word;
                        in_ready_n  = 1'b0;
                        out_valid_n = 1'b1;
                        busy_n      = 1'b1;
                        out_idx_n   = lsb_idx(in_word);
                        out_last_n  = single_bit(in_word);
                    end else begin
                        zero_flag_n = 1'b1;
                    end
                end
            end
            EMIT: begin
                if (out_valid && out_ready) begin
                    if (out_last) begin
                        state_n     = IDLE;
                        pending_n   = '0;
                        in_ready_n  = 1'b1;
                        out_valid_n = 1'b0;
                        busy_n      = 1'b0;
                        out_idx_n   = '0;
                        out_last_n  = 1'b0;
                    end else begin
                        pending_n  = rem;
                        out_idx_n  = lsb_idx(rem);
                        out_last_n = single_bit(rem);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            pending   <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_idx   <= '0;
            out_last  <= 1'b0;
            zero_flag <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            pending   <= pending_n;
            in_ready  <= in_ready_n;
            out_valid <= out_valid_n;
            out_idx   <= out_idx_n;
            out_last  <= out_last_n;
            zero_flag <= zero_flag_n;
            busy      <= busy_n;
        end
    end

endmodule
